hazard_detect: RTL and testbench

Hazard detection unit for the 32I five-stage pipeline; the producer of the hazard flags and codes consumed by `forwarding`. It tracks the destination registers of the two instructions ahead of decode (EX and MEM slots) and compares them against the decode-stage source registers. It emits registered per-slot hazard flags and forwarding codes aligned with the ID/EX boundary, plus a combinational load-use stall. A saturating stall counter is included for performance visibility.

---
 rtl/hazard_detect.sv | 116 +++++++++++
 tb/tb_hazard_detect.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_detect.sv
// hazard_detect: RAW hazard flags/codes for the EX and MEM producer slots, plus load-use stall.
// Latency: hazard flags, codes and dual bits are registered (valid the cycle after decode); stall is combinational.
// Backpressure: stall holds PC/IF/ID for one cycle per load-use pair and inserts a bubble; flush overrides stall.
// Ports: clk, reset (async, active-high); id_* decode-stage instruction fields; flush redirect;
//        stall out; is_hazard1/hazard_reg1/dual1 (EX slot); is_hazard2/hazard_reg2/dual2 (MEM slot);
//        stall_count saturating count of stall cycles.
module hazard_detect #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic             is_hazard1,
  output logic [2:0]       hazard_reg1,
  output logic             is_hazard2,
  output logic [2:0]       hazard_reg2,
  output logic             dual1,
  output logic             dual2,
  output logic [CNT_W-1:0] stall_count
);

  // Producer history. The MEM slot keeps no load bit: a load that has reached
  // MEM is forwarded from mem rdata and never needs a stall.
  logic       ex_valid;
  logic [4:0] ex_rd;
  logic       ex_we;
  logic       ex_load;
  logic       mem_valid;
  logic [4:0] mem_rd;
  logic       mem_we;

  // A source is live only if decode holds a real instruction that actually
  // reads it, and it is not x0 (x0 is never a true dependency).
  logic rs1_live;
  logic rs2_live;
  logic ex_rs1;
  logic ex_rs2;
  logic mem_rs1;
  logic mem_rs2;
  logic kill;

  assign rs1_live = id_valid && id_use_rs1 && (id_rs1 != 5'd0);
  assign rs2_live = id_valid && id_use_rs2 && (id_rs2 != 5'd0);

  assign ex_rs1  = rs1_live && ex_valid  && ex_we  && (ex_rd  == id_rs1);
  assign ex_rs2  = rs2_live && ex_valid  && ex_we  && (ex_rd  == id_rs2);
  assign mem_rs1 = rs1_live && mem_valid && mem_we && (mem_rd == id_rs1);
  assign mem_rs2 = rs2_live && mem_valid && mem_we && (mem_rd == id_rs2);

  // A redirect discards the dependent instruction, so it must not stall.
  assign stall = ex_load && (ex_rs1 || ex_rs2) && !flush;

  // Either case puts a bubble into ID/EX, so nothing downstream should forward.
  assign kill = stall || flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_rd       <= 5'd0;
      ex_we       <= 1'b0;
      ex_load     <= 1'b0;
      mem_valid   <= 1'b0;
      mem_rd      <= 5'd0;
      mem_we      <= 1'b0;
      is_hazard1  <= 1'b0;
      hazard_reg1 <= 3'd0;
      dual1       <= 1'b0;
      is_hazard2  <= 1'b0;
      hazard_reg2 <= 3'd0;
      dual2       <= 1'b0;
      stall_count <= '0;
    end else begin
      // The EX-slot instruction is already past the branch decision, so it
      // moves to MEM even on a flush.
      mem_valid <= ex_valid;
      mem_rd    <= ex_rd;
      mem_we    <= ex_we;

      ex_valid <= id_valid && !kill;
      ex_rd    <= id_rd;
      ex_we    <= id_rd_we;
      ex_load  <= id_is_load;

      if (kill) begin
        is_hazard1  <= 1'b0;
        hazard_reg1 <= 3'd0;
        dual1       <= 1'b0;
        is_hazard2  <= 1'b0;
        hazard_reg2 <= 3'd0;
        dual2       <= 1'b0;
      end else begin
        // rs1 takes priority in the code; dual tells forwarding both sources hit.
        is_hazard1  <= ex_rs1 || ex_rs2;
        hazard_reg1 <= ex_rs1 ? 3'd1 : (ex_rs2 ? 3'd2 : 3'd0);
        dual1       <= ex_rs1 && ex_rs2;
        is_hazard2  <= mem_rs1 || mem_rs2;
        hazard_reg2 <= mem_rs1 ? 3'd3 : (mem_rs2 ? 3'd4 : 3'd0);
        dual2       <= mem_rs1 && mem_rs2;
      end

      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_hazard_detect.sv
// tb_hazard_detect: directed and randomized checks of hazard_detect against a queue-based model.
// Latency: model predicts registered outputs one edge after each decode presentation.
// Backpressure: the stimulus holds the decode instruction for a cycle whenever stall is seen.
module tb_hazard_detect;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             id_valid = 1'b0;
  logic [4:0]       id_rs1 = 5'd0;
  logic [4:0]       id_rs2 = 5'd0;
  logic             id_use_rs1 = 1'b0;
  logic             id_use_rs2 = 1'b0;
  logic [4:0]       id_rd = 5'd0;
  logic             id_rd_we = 1'b0;
  logic             id_is_load = 1'b0;
  logic             flush = 1'b0;
  logic             stall;
  logic             is_hazard1;
  logic [2:0]       hazard_reg1;
  logic             is_hazard2;
  logic [2:0]       hazard_reg2;
  logic             dual1;
  logic             dual2;
  logic [CNT_W-1:0] stall_count;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  hazard_detect #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_rd_we    (id_rd_we),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .stall       (stall),
    .is_hazard1  (is_hazard1),
    .hazard_reg1 (hazard_reg1),
    .is_hazard2  (is_hazard2),
    .hazard_reg2 (hazard_reg2),
    .dual1       (dual1),
    .dual2       (dual2),
    .stall_count (stall_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // hist[0] is whatever entered ID/EX one edge ago, hist[1] two edges ago.
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       we;
    logic       ld;
  } slot_t;

  slot_t hist[$];

  function automatic bit hits(slot_t s, logic [4:0] src, logic used);
    return id_valid && used && (src != 5'd0) && s.v && s.we && (s.rd == src);
  endfunction

  initial begin
    bit               e_flag [2];
    logic [2:0]       e_code [2];
    bit               e_dual [2];
    bit               m_flag [2];
    logic [2:0]       m_code [2];
    bit               m_dual [2];
    logic [CNT_W-1:0] e_cnt;
    bit               e_stall;
    bit               a;
    bit               b;
    slot_t            s;
    slot_t            ent;
    for (int k = 0; k < 2; k++) begin
      e_flag[k] = 0; e_code[k] = 0; e_dual[k] = 0;
    end
    e_cnt = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hist = {};
        for (int k = 0; k < 2; k++) begin
          e_flag[k] = 0; e_code[k] = 0; e_dual[k] = 0;
        end
        e_cnt = '0;
      end
      // Distance d: code 2d-1 for rs1, 2d for rs2.
      for (int d = 1; d <= 2; d++) begin
        s = (hist.size() >= d) ? hist[d-1] : '0;
        a = hits(s, id_rs1, id_use_rs1);
        b = hits(s, id_rs2, id_use_rs2);
        m_flag[d-1] = a || b;
        m_code[d-1] = a ? 3'(2*d - 1) : (b ? 3'(2*d) : 3'd0);
        m_dual[d-1] = a && b;
      end
      s = (hist.size() >= 1) ? hist[0] : '0;
      e_stall = !reset && !flush && s.ld && m_flag[0];

      check("stall", stall, e_stall);
      check("is_hazard1", is_hazard1, e_flag[0]);
      check("hazard_reg1", hazard_reg1, e_code[0]);
      check("dual1", dual1, e_dual[0]);
      check("is_hazard2", is_hazard2, e_flag[1]);
      check("hazard_reg2", hazard_reg2, e_code[1]);
      check("dual2", dual2, e_dual[1]);
      check("stall_count", stall_count, e_cnt);

      if (!reset) begin
        for (int k = 0; k < 2; k++) begin
          e_flag[k] = (e_stall || flush) ? 1'b0 : m_flag[k];
          e_code[k] = (e_stall || flush) ? 3'd0 : m_code[k];
          e_dual[k] = (e_stall || flush) ? 1'b0 : m_dual[k];
        end
        ent.v  = id_valid && !e_stall && !flush;
        ent.rd = id_rd;
        ent.we = id_rd_we;
        ent.ld = id_is_load;
        hist.push_front(ent);
        if (hist.size() > 2) void'(hist.pop_back());
        if (e_stall && e_cnt != {CNT_W{1'b1}}) e_cnt = e_cnt + 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at posedge+1; returns at the next posedge+1 with stall as seen mid-cycle.
  task automatic issue(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic we, input logic ld, input logic fl, output logic st);
    id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld; flush = fl;
    @(negedge clk);
    #1;
    st = stall;
    @(posedge clk);
    #1;
  endtask

  task automatic bubbles(input int n);
    logic st;
    for (int k = 0; k < n; k++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0, st);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic st;
    logic [4:0] r1, r2, rd;
    logic v, u1, u2, we, ld, fl;
    int nstall;

    #2;
    check("reset_is_hazard1", is_hazard1, 0);
    check("reset_hazard_reg2", hazard_reg2, 0);
    check("reset_stall_count", stall_count, 0);
    check("reset_stall", stall, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // addi x5,x1,1 ; add x6,x5,x7
    issue(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 0, st);
    check("t1_stall_a", st, 0);
    issue(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, st);
    check("t1_stall_b", st, 0);
    check("t1_is_hazard1", is_hazard1, 1);
    check("t1_hazard_reg1", hazard_reg1, 1);
    check("t1_is_hazard2", is_hazard2, 0);
    bubbles(2);

    // addi x5 ; nop ; sub x8,x9,x5
    issue(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 0, st);
    issue(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, st);
    issue(1, 5'd9, 1, 5'd5, 1, 5'd8, 1, 0, 0, st);
    check("t2_is_hazard2", is_hazard2, 1);
    check("t2_hazard_reg2", hazard_reg2, 4);
    check("t2_is_hazard1", is_hazard1, 0);
    bubbles(2);

    // lw x5,0(x2) ; add x6,x5,x5
    issue(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0, st);
    issue(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, st);
    check("t3_stall_on", st, 1);
    check("t3_bubble_h1", is_hazard1, 0);
    check("t3_bubble_h2", is_hazard2, 0);
    check("t3_bubble_r2", hazard_reg2, 0);
    issue(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, st);
    check("t3_stall_off", st, 0);
    check("t3_is_hazard2", is_hazard2, 1);
    check("t3_hazard_reg2", hazard_reg2, 3);
    check("t3_dual2", dual2, 1);
    check("t3_is_hazard1", is_hazard1, 0);
    check("t3_stall_count", stall_count, 1);
    bubbles(2);

    // addi x5 ; addi x5 ; add x1,x5,x0 then addi x0 ; add x1,x0,x0
    issue(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 0, st);
    issue(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 0, st);
    issue(1, 5'd5, 1, 5'd0, 1, 5'd1, 1, 0, 0, st);
    check("t4_is_hazard1", is_hazard1, 1);
    check("t4_hazard_reg1", hazard_reg1, 1);
    check("t4_is_hazard2", is_hazard2, 1);
    check("t4_hazard_reg2", hazard_reg2, 3);
    check("t4_dual1", dual1, 0);
    issue(1, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, st);
    issue(1, 5'd0, 1, 5'd0, 1, 5'd1, 1, 0, 0, st);
    check("t4_x0_h1", is_hazard1, 0);
    check("t4_x0_h2", is_hazard2, 0);
    bubbles(2);

    // lw x5 in EX, dependent in decode with flush
    issue(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0, st);
    issue(1, 5'd5, 1, 5'd0, 1, 5'd6, 1, 0, 1, st);
    check("t5_flush_stall", st, 0);
    check("t5_flush_h1", is_hazard1, 0);
    check("t5_flush_cnt", stall_count, 1);
    issue(1, 5'd5, 1, 5'd0, 0, 5'd7, 1, 0, 0, st);
    check("t5_after_stall", st, 0);
    check("t5_after_h1", is_hazard1, 0);
    check("t5_after_h2", is_hazard2, 1);
    check("t5_after_r2", hazard_reg2, 3);
    bubbles(2);

    // asynchronous reset mid-stream
    issue(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 0, 0, st);
    issue(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 1, 0, st);
    check("t6_pre_h1", is_hazard1, 1);
    id_valid = 1; id_rs1 = 5'd6; id_use_rs1 = 1; id_rs2 = 5'd0; id_use_rs2 = 0;
    id_rd = 5'd7; id_rd_we = 1; id_is_load = 0; flush = 0;
    #1;
    check("t6_pre_stall", stall, 1);
    reset = 1'b1;
    #1;
    check("t6_rst_stall", stall, 0);
    check("t6_rst_h1", is_hazard1, 0);
    check("t6_rst_r1", hazard_reg1, 0);
    check("t6_rst_cnt", stall_count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    issue(1, 5'd6, 1, 5'd5, 1, 5'd7, 1, 0, 0, st);
    check("t6_post_stall", st, 0);
    check("t6_post_h1", is_hazard1, 0);
    check("t6_post_h2", is_hazard2, 0);

    // saturation: 20 load-use pairs on a 4-bit counter
    nstall = 0;
    for (int k = 0; k < 20; k++) begin
      issue(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 0, st);
      issue(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, st);
      if (st) nstall++;
      issue(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, st);
    end
    check("t7_stall_events", nstall, 20);
    check("t7_saturated", stall_count, 15);

    // randomized traffic, holding the instruction while stalled
    pulse_reset();
    st = 0;
    v = 0; r1 = 0; r2 = 0; rd = 0; u1 = 0; u2 = 0; we = 0; ld = 0;
    for (int k = 0; k < 3000; k++) begin
      if (!st) begin
        v  = ($urandom_range(0, 7) != 0);
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        u1 = ($urandom_range(0, 3) != 0);
        u2 = ($urandom_range(0, 1) != 0);
        we = ($urandom_range(0, 4) != 0);
        ld = ($urandom_range(0, 2) == 0);
      end
      fl = ($urandom_range(0, 9) == 0);
      if (k == 1500) pulse_reset();
      issue(v, r1, u1, r2, u2, rd, we, ld, fl, st);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
